// File: rtl/byte_mem_seq_if.sv
// ---------------------------------------------------------------------------
// byte_mem_seq_if
//   CPU-side request/response bundle for the byte_mem_seq sequencer.
//
//   Request channel (valid/ready, one outstanding request at a time):
//     req_valid  : request present
//     req_ready  : sequencer idle and able to accept
//     req_op     : 000 LW, 001 SW, 010 LB, 011 LBU, 100 SB, others illegal
//     req_addr   : byte address
//     req_wdata  : store data (SB uses bits [7:0])
//   Response channel (single-cycle pulse):
//     resp_valid : completion pulse
//     resp_rdata : load result, 0 for stores and errors
//     resp_err   : error flag, meaningful only with resp_valid
//
//   master = CPU memory stage, slave = sequencer.
// ---------------------------------------------------------------------------
interface byte_mem_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/byte_mem_seq.sv
// ---------------------------------------------------------------------------
// byte_mem_seq
//   Multi-cycle sequencer between the CPU memory stage and a word-addressed,
//   single-port data memory with one cycle of read latency. Byte loads
//   (LB/LBU) read the containing word and extract one lane; byte stores (SB)
//   are done as read-modify-write of the containing word.
//
//   Ports:
//     clk        : system clock, rising edge
//     rst        : synchronous active-high reset
//     cpu        : byte_mem_seq_if.slave request/response bundle
//     mem_addr   : word-aligned memory address (0 when no strobe)
//     mem_re     : memory read strobe
//     mem_we     : memory write strobe
//     mem_wdata  : memory write data (0 when no write)
//     mem_rdata  : memory read data, valid the cycle after mem_re
//
//   Parameter:
//     MEM_RD_LAT : memory read latency; only 1 is supported.
//
//   Optional feature (macro BYTE_MEM_SEQ_ALIGN_CHECK_EN):
//     defined   -> LW/SW with addr[1:0] != 0 respond with resp_err=1 one
//                  cycle after acceptance and never touch memory.
//     undefined -> word ops simply ignore addr[1:0].
//
//   Latency from accept cycle T to resp_valid:
//     illegal/misaligned T+1, SW T+2, LW/LB/LBU T+3, SB T+4.
// ---------------------------------------------------------------------------
module byte_mem_seq #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    byte_mem_seq_if.slave       cpu,
    output logic [31:0]         mem_addr,
    output logic                mem_re,
    output logic                mem_we,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    // The RD -> CAP timing below assumes read data arrives exactly one cycle
    // after the strobe.
    generate
        if (MEM_RD_LAT != 1) begin : g_bad_rd_lat
            $error("byte_mem_seq: MEM_RD_LAT must be 1");
        end
    endgenerate

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_LB  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] word_reg, word_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;
    logic        resp_err_reg, resp_err_next;

    logic        accept;
    logic        op_illegal;
    logic        op_misaligned;
    logic [1:0]  lane;
    logic [7:0]  rd_lane [4];
    logic [7:0]  sel_byte;
    logic [31:0] merged_word;
    logic [31:0] load_result;

    assign cpu.req_ready = (state_reg == ST_IDLE) && !rst;
    assign accept        = cpu.req_valid && cpu.req_ready;
    assign op_illegal    = (cpu.req_op > OP_SB);

`ifdef BYTE_MEM_SEQ_ALIGN_CHECK_EN
    assign op_misaligned = ((cpu.req_op == OP_LW) || (cpu.req_op == OP_SW)) &&
                           (cpu.req_addr[1:0] != 2'b00);
`else
    assign op_misaligned = 1'b0;
`endif

    // Little-endian lane handling: lane k is word[8k+7:8k]. Loads pick the
    // lane straight from the returning memory data; SB merges into the word
    // captured during CAP.
    assign lane = addr_reg[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_lane[gi] = mem_rdata[8*gi +: 8];
            assign merged_word[8*gi +: 8] = (lane == gi[1:0]) ? wdata_reg[7:0]
                                                              : word_reg[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_lane[lane];

    always_comb begin
        load_result = 32'd0;
        case (op_reg)
            OP_LW:   load_result = mem_rdata;
            OP_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_result = {24'd0, sel_byte};
            default: load_result = 32'd0;
        endcase
    end

    // Strobes are killed combinationally by rst so that an in-flight SB
    // write is abandoned in the very cycle reset is seen.
    assign mem_re    = (state_reg == ST_RD) && !rst;
    assign mem_we    = (state_reg == ST_WR) && !rst;
    assign mem_addr  = (mem_re || mem_we) ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem_wdata = mem_we ? ((op_reg == OP_SB) ? merged_word : wdata_reg)
                              : 32'd0;

    // Response outputs are registered and only reloaded on entry to RESP,
    // so they hold between responses.
    assign cpu.resp_valid = resp_valid_reg;
    assign cpu.resp_rdata = resp_rdata_reg;
    assign cpu.resp_err   = resp_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            op_reg         <= 3'd0;
            addr_reg       <= 32'd0;
            wdata_reg      <= 32'd0;
            word_reg       <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            word_reg       <= word_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
            resp_err_reg   <= resp_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        word_next       = word_reg;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;
        resp_err_next   = resp_err_reg;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    op_next    = cpu.req_op;
                    addr_next  = cpu.req_addr;
                    wdata_next = cpu.req_wdata;
                    if (op_illegal || op_misaligned) begin
                        state_next      = ST_RESP;
                        resp_valid_next = 1'b1;
                        resp_rdata_next = 32'd0;
                        resp_err_next   = 1'b1;
                    end else if (cpu.req_op == OP_SW) begin
                        state_next = ST_WR;
                    end else begin
                        state_next = ST_RD;
                    end
                end
            end

            ST_RD: begin
                state_next = ST_CAP;
            end

            ST_CAP: begin
                word_next = mem_rdata;
                if (op_reg == OP_SB) begin
                    state_next = ST_WR;
                end else begin
                    state_next      = ST_RESP;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = load_result;
                    resp_err_next   = 1'b0;
                end
            end

            ST_WR: begin
                state_next      = ST_RESP;
                resp_valid_next = 1'b1;
                resp_rdata_next = 32'd0;
                resp_err_next   = 1'b0;
            end

            ST_RESP: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_mem_seq.sv
// ---------------------------------------------------------------------------
// tb_byte_mem_seq
//   Self-checking bench for byte_mem_seq: directed scenarios followed by
//   random traffic, checked against a transaction-level reference model
//   (word array + arithmetic byte extraction/merge + fixed latency table).
// ---------------------------------------------------------------------------
module tb_byte_mem_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_init;

    int n_checks = 0;
    int n_errs   = 0;

    byte_mem_seq_if bus ();

    byte_mem_seq #(.MEM_RD_LAT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (bus),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // Data memory: 256 words, one-cycle registered read.
    logic [31:0] tb_mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
        end else begin
            if (mem_we) tb_mem[mem_addr[9:2]] <= mem_wdata;
            if (mem_re) mem_rdata <= tb_mem[mem_addr[9:2]];
        end
    end

    // Reference memory image.
    logic [31:0] ref_mem [256];

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Transaction-level model: result, latency and memory traffic.
    task automatic model(input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata,
                         output logic err, output int reads, output int writes,
                         output logic [31:0] wdat);
        int          idx;
        int          k;
        logic [31:0] word;
        logic [31:0] b;
        logic        misal;
        idx    = int'(addr[9:2]);
        k      = int'(addr[1:0]);
        word   = ref_mem[idx];
        b      = (word >> (8 * k)) & 32'hFF;
        rdata  = 32'd0;
        err    = 1'b0;
        reads  = 0;
        writes = 0;
        wdat   = 32'd0;
        lat    = 1;
        misal  = 1'b0;
`ifdef BYTE_MEM_SEQ_ALIGN_CHECK_EN
        misal = (op <= 3'd1) && (k != 0);
`endif
        if (op > 3'd4 || misal) begin
            lat = 1;
            err = 1'b1;
        end else begin
            case (op)
                3'd0: begin lat = 3; reads = 1; rdata = word; end
                3'd1: begin lat = 2; writes = 1; wdat = wd; ref_mem[idx] = wd; end
                3'd2: begin lat = 3; reads = 1;
                            rdata = (b >= 128) ? (b | 32'hFFFFFF00) : b; end
                3'd3: begin lat = 3; reads = 1; rdata = b; end
                default: begin
                    lat = 4; reads = 1; writes = 1;
                    wdat = (word & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
                    ref_mem[idx] = wdat;
                end
            endcase
        end
    endtask

    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd,
                          output logic [31:0] got_rdata, output logic got_err);
        int          lat, reads, writes, cyc, seen_r, seen_w;
        logic [31:0] e_rdata, e_wdat, e_addr;
        logic        e_err, done;
        model(op, addr, wd, lat, e_rdata, e_err, reads, writes, e_wdat);
        e_addr    = {addr[31:2], 2'b00};
        got_rdata = 32'd0;
        got_err   = 1'b0;

        @(negedge clk);
        check_eq("idle_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        // Keep a bogus SW asserted while busy; it must be ignored.
        bus.req_op    = 3'b001;
        bus.req_addr  = 32'h0000_03FC;
        bus.req_wdata = 32'hBAD0_BAD0;

        cyc = 0; done = 1'b0; seen_r = 0; seen_w = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_re) begin
                seen_r++;
                check_eq("re_cycle", cyc, 1);
                check_eq("re_addr", mem_addr, e_addr);
            end
            if (mem_we) begin
                seen_w++;
                check_eq("we_cycle", cyc, lat - 1);
                check_eq("we_addr", mem_addr, e_addr);
                check_eq("we_data", mem_wdata, e_wdat);
            end
            if (!mem_re && !mem_we) begin
                check_eq("idle_maddr", mem_addr, 32'd0);
                check_eq("idle_mwdata", mem_wdata, 32'd0);
            end
            if (bus.resp_valid) begin
                done      = 1'b1;
                got_rdata = bus.resp_rdata;
                got_err   = bus.resp_err;
                check_eq("latency", cyc, lat);
                check_eq("rdata", bus.resp_rdata, e_rdata);
                check_eq("err", {31'd0, bus.resp_err}, {31'd0, e_err});
                check_eq("resp_ready", {31'd0, bus.req_ready}, 32'd0);
                bus.req_valid = 1'b0;
            end else begin
                check_eq("busy_ready", {31'd0, bus.req_ready}, 32'd0);
            end
        end
        bus.req_valid = 1'b0;
        if (!done) check_eq("resp_timeout", 32'd0, 32'd1);
        check_eq("n_reads", seen_r, reads);
        check_eq("n_writes", seen_w, writes);

        @(negedge clk);
        check_eq("pulse_1cyc", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("rdata_hold", bus.resp_rdata, e_rdata);
        check_eq("err_hold", {31'd0, bus.resp_err}, {31'd0, e_err});
        $display("txn op=%0d addr=0x%08h wd=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 op, addr, wd, got_rdata, got_err, cyc);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [2:0]  op;
        logic [31:0] addr;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        rst           = 1'b1;
        mem_init      = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;

        // 1. Reset / idle
        @(negedge clk);
        check_eq("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        check_eq("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("post_rst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
        check_eq("post_rst_rdata", bus.resp_rdata, 32'd0);
        check_eq("post_rst_err", {31'd0, bus.resp_err}, 32'd0);
        check_eq("post_rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        check_eq("post_rst_maddr", mem_addr, 32'd0);
        check_eq("post_rst_mwdata", mem_wdata, 32'd0);

        // 2. SW then LW
        do_txn(3'd1, 32'h100, 32'hDEADBEEF, r, e);
        do_txn(3'd0, 32'h100, 32'd0, r, e);
        check_eq("lw_100", r, 32'hDEADBEEF);

        // 3. LB/LBU sign handling
        do_txn(3'd1, 32'h200, 32'h80FF7F01, r, e);
        do_txn(3'd2, 32'h203, 32'd0, r, e);
        check_eq("lb_203", r, 32'hFFFFFF80);
        do_txn(3'd3, 32'h203, 32'd0, r, e);
        check_eq("lbu_203", r, 32'h00000080);
        do_txn(3'd2, 32'h202, 32'd0, r, e);
        check_eq("lb_202", r, 32'hFFFFFFFF);
        do_txn(3'd2, 32'h201, 32'd0, r, e);
        check_eq("lb_201", r, 32'h0000007F);

        // 4. SB read-modify-write
        do_txn(3'd1, 32'h300, 32'h11223344, r, e);
        do_txn(3'd4, 32'h301, 32'h000000AB, r, e);
        do_txn(3'd0, 32'h300, 32'd0, r, e);
        check_eq("lw_300_sb", r, 32'h1122AB44);

        // 5. Reset during the WR cycle of an SB
        do_txn(3'd1, 32'h300, 32'h11223344, r, e);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd4;
        bus.req_addr  = 32'h301;
        bus.req_wdata = 32'h000000AB;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("abort_rd", {31'd0, mem_re}, 32'd1);
        @(posedge clk);                 // RD -> CAP
        @(posedge clk);                 // CAP -> WR
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_we", {31'd0, mem_we}, 32'd0);
        check_eq("abort_rvalid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        check_eq("abort_rvalid2", {31'd0, bus.resp_valid}, 32'd0);
        do_txn(3'd0, 32'h300, 32'd0, r, e);
        check_eq("abort_mem_kept", r, 32'h11223344);

        // 6. Illegal op and misaligned word access
        do_txn(3'd7, 32'h100, 32'd0, r, e);
        check_eq("illegal_err", {31'd0, e}, 32'd1);
        do_txn(3'd0, 32'h102, 32'd0, r, e);
`ifdef BYTE_MEM_SEQ_ALIGN_CHECK_EN
        check_eq("lw_102_err", {31'd0, e}, 32'd1);
        check_eq("lw_102_rdata", r, 32'd0);
`else
        check_eq("lw_102_rdata", r, 32'hDEADBEEF);
        check_eq("lw_102_err", {31'd0, e}, 32'd0);
`endif

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            op   = 3'($urandom_range(0, 7));
            addr = $urandom & 32'hFFF0_03FF;
            do_txn(op, addr, $urandom, r, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/byte_mem_seq.md
Name: byte_mem_seq

Overview:
- Multi-cycle sequencer placed between the CPU memory stage and a word-addressed, single-port data memory.
- Converts byte accesses (LB, LBU, SB) into aligned word accesses.
- SB is performed as a read-modify-write: read the word, merge one byte lane, write the word back.
- Uses a single-request valid/ready front end and a one-cycle response pulse, so the CPU FSM stalls until the response.

Parameters:
- MEM_RD_LAT, 1, data memory read latency in cycles; fixed at 1 (any other value is a compile-time error).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle, can accept a request.
- req_op  in  3  operation: 000 LW, 001 SW, 010 LB, 011 LBU, 100 SB; all other codes are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; SB uses bits [7:0].
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  error flag, valid only with resp_valid.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  read data, valid the cycle after mem_re.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE; all latched registers 0; resp_valid=0, resp_err=0, resp_rdata=0.
- Strobe gating: mem_re and mem_we are gated by !rst, so no memory access occurs in any cycle where rst=1.
- req_ready = (state==IDLE) && !rst.
- Memory outputs are decoded from state and latched registers. mem_addr and mem_wdata are 0 when no strobe is active.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE, on req_valid && req_ready: latch op, addr and wdata, then:
  - SW → WR.
  - LW, LB, LBU, SB → RD.
  - Illegal op → RESP with err=1; no memory access.
- RD: mem_re=1. Next state CAP.
- CAP: capture mem_rdata into word_q.
  - LW: rdata = word_q. Next RESP.
  - LB: rdata = sign-extended byte k, where k = addr[1:0] and byte k = word[8k+7:8k] (little-endian). Next RESP.
  - LBU: rdata = zero-extended byte k. Next RESP.
  - SB: form merged word = word_q with lane k replaced by wdata[7:0]. Next WR.
- WR: mem_we=1.
  - mem_wdata = wdata for SW; merged word for SB.
  - Next RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata and resp_err. Next IDLE.
  - req_ready remains 0 in RESP; a new request is accepted no earlier than the following cycle.
- Latency from the accept cycle T to resp_valid:
  - SW: T+2.
  - LW / LB / LBU: T+3.
  - SB: T+4.
  - Illegal op: T+1.
- Requests presented while req_ready=0 are ignored and not latched.
- Word accesses without the optional feature ignore addr[1:0].
- Byte accesses never fault on alignment.
- Reset mid-operation: the FSM returns to IDLE on the next edge. An in-flight SB write is abandoned (mem_we=0 in the reset cycle), and no resp_valid is issued for the aborted request.
- resp_rdata and resp_err hold their values after RESP until the next RESP.

Optional Feature:
- Macro: BYTE_MEM_SEQ_ALIGN_CHECK_EN.
- Defined: LW/SW with addr[1:0]≠00 take IDLE → RESP with resp_err=1 and resp_rdata=0, latency T+1, and no mem_re/mem_we.
- Undefined: word ops force addr[1:0] to 00 and proceed normally; resp_err is asserted only for illegal ops.

Test Plan:
1. Reset/idle: hold rst for 2 cycles, then release → req_ready=1, resp_valid=0, mem_re=mem_we=0, and all outputs 0.
2. SW then LW: SW addr 0x100, data 0xDEADBEEF → mem_we at T+1 with mem_addr 0x100, resp at T+2. Then LW 0x100 → resp_rdata 0xDEADBEEF at T+3.
3. LB/LBU sign handling: memory word 0x80FF7F01 at 0x200.
   - LB 0x203 → 0xFFFFFF80.
   - LBU 0x203 → 0x00000080.
   - LB 0x202 → 0xFFFFFFFF.
   - LB 0x201 → 0x0000007F.
4. SB read-modify-write: word 0x11223344 at 0x300, SB addr 0x301 data 0xAB → mem_re at T+1, mem_we at T+3 with mem_wdata 0x1122AB44, resp at T+4. A subsequent LW returns 0x1122AB44.
5. Reset in WR of SB: assert rst in the WR cycle → mem_we=0 that cycle, memory keeps 0x11223344, no resp_valid, FSM in IDLE.
6. Illegal op 111 → resp_err=1 at T+1 with no memory strobe. With BYTE_MEM_SEQ_ALIGN_CHECK_EN, LW 0x102 → resp_err=1 at T+1; without the macro, LW 0x102 reads 0x100.
